// File: rtl/siso_pkg.sv
// Shared constants for the siso_4_bit shift register: default width,
// shift-direction encoding and default stage contents after reset.
package siso_pkg;

    localparam int          DEFAULT_WIDTH       = 4;
    localparam bit          SHIFT_MSB_FIRST     = 1'b1;
    localparam bit          SHIFT_LSB_FIRST     = 1'b0;
    localparam logic [31:0] DEFAULT_RESET_VALUE = 32'h0000_0000;

endpackage : siso_pkg

// File: rtl/siso_stage.sv
// One shift-register stage: a D flop with synchronous active-low reset
// that loads its own reset bit.
module siso_stage #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            q <= RESET_BIT;
        end else begin
            q <= d;
        end
    end

endmodule : siso_stage

// File: rtl/siso_4_bit.sv
// Serial-in serial-out shift register with parallel view of all stages.
// Optional simulation checks are compiled in with SISO_4_BIT_ASSERT_EN.
module siso_4_bit
    import siso_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter bit               MSB_FIRST   = SHIFT_MSB_FIRST,
    parameter logic [WIDTH-1:0] RESET_VALUE = DEFAULT_RESET_VALUE[WIDTH-1:0]
) (
    output logic             sout,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    input  logic             clock,
    input  logic             reset
);

    logic [WIDTH-1:0] d;

    // Each stage is fed by its upstream neighbour; the entry stage takes sin.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        if (MSB_FIRST) begin : g_msb
            if (i == 0) begin : g_entry
                assign d[i] = sin;
            end else begin : g_link
                assign d[i] = q[i-1];
            end
        end else begin : g_lsb
            if (i == WIDTH - 1) begin : g_entry
                assign d[i] = sin;
            end else begin : g_link
                assign d[i] = q[i+1];
            end
        end

        siso_stage #(
            .RESET_BIT(RESET_VALUE[i])
        ) u_stage (
            .clock(clock),
            .reset(reset),
            .d    (d[i]),
            .q    (q[i])
        );
    end

    assign sout = MSB_FIRST ? q[WIDTH-1] : q[0];

`ifdef SISO_4_BIT_ASSERT_EN
    localparam bit [5:0] WIDTH6 = 6'(WIDTH);

    bit [WIDTH-1:0] sin_hist;
    bit [5:0]       clean_cnt;
    bit             reset_was_low;

    // sin_hist[WIDTH-1] holds the bit sampled WIDTH edges ago, which must be
    // on sout now if no reset edge fell inside that window.
    always @(posedge clock) begin
        if (reset === 1'b1 && $isunknown(sin)) begin
            $error("siso_4_bit: sin is X/Z at a shifting edge");
        end
        if (reset_was_low && q !== RESET_VALUE) begin
            $error("siso_4_bit: q=%b after reset, expected %b", q, RESET_VALUE);
        end
        if (clean_cnt >= WIDTH6 && sout !== sin_hist[WIDTH-1]) begin
            $error("siso_4_bit: sout=%b, expected delayed sin %b", sout, sin_hist[WIDTH-1]);
        end
        sin_hist      <= {sin_hist[WIDTH-2:0], sin};
        reset_was_low <= (reset == 1'b0);
        if (reset == 1'b0) begin
            clean_cnt <= 6'd0;
        end else if (clean_cnt < 6'd63) begin
            clean_cnt <= clean_cnt + 6'd1;
        end
    end
`endif

endmodule : siso_4_bit

// File: tb/tb_siso_4_bit.sv
// Bench for siso_4_bit: three instances (default, LSB-first, 8 stages) share
// sin/reset; expectations are queued at drive time and checked by a monitor.
module tb_siso_4_bit;

    logic       clock;
    logic       reset;
    logic       sin;
    logic [3:0] q_a;
    logic       sout_a;
    logic [3:0] q_b;
    logic       sout_b;
    logic [7:0] q_c;
    logic       sout_c;

    int checks = 0;
    int errors = 0;

    // Packed as {sout, q}
    logic [4:0] exp_a_q[$];
    logic [4:0] exp_b_q[$];
    logic [8:0] exp_c_q[$];

    // Sampled sin bits since the last reset, newest at index 0
    logic hist[$];

    siso_4_bit dut_a (
        .sout (sout_a),
        .sin  (sin),
        .q    (q_a),
        .clock(clock),
        .reset(reset)
    );

    siso_4_bit #(
        .MSB_FIRST(1'b0)
    ) dut_b (
        .sout (sout_b),
        .sin  (sin),
        .q    (q_b),
        .clock(clock),
        .reset(reset)
    );

    siso_4_bit #(
        .WIDTH(8)
    ) dut_c (
        .sout (sout_c),
        .sin  (sin),
        .q    (q_c),
        .clock(clock),
        .reset(reset)
    );

    // Clock and reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        reset = 1'b0;
        sin   = 1'b0;
    end

    // Reference FIFO views of the sampled bits
    function automatic logic [4:0] model_a();
        logic [4:0] r;
        for (int i = 0; i < 4; i++) r[i] = hist[i];
        r[4] = hist[3];
        return r;
    endfunction

    function automatic logic [4:0] model_b();
        logic [4:0] r;
        for (int i = 0; i < 4; i++) r[3-i] = hist[i];
        r[4] = hist[3];
        return r;
    endfunction

    function automatic logic [8:0] model_c();
        logic [8:0] r;
        for (int i = 0; i < 8; i++) r[i] = hist[i];
        r[8] = hist[7];
        return r;
    endfunction

    // Driver tasks: inputs change on the falling edge
    task automatic drive(input logic s, input logic r);
        @(negedge clock);
        sin   = s;
        reset = r;
        if (!r) begin
            hist.delete();
            repeat (8) hist.push_front(1'b0);
        end else begin
            hist.push_front(s);
            if (hist.size() > 8) void'(hist.pop_back());
        end
    endtask

    task automatic step_hand(input logic s, input logic r, input logic [4:0] ea,
                             input logic [4:0] eb, input logic [8:0] ec);
        drive(s, r);
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);
        exp_c_q.push_back(ec);
    endtask

    task automatic step_model(input logic s, input logic r);
        drive(s, r);
        exp_a_q.push_back(model_a());
        exp_b_q.push_back(model_b());
        exp_c_q.push_back(model_c());
    endtask

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got {sout,q}=%b want %b", name, $time, got, want);
        end
    endtask

    // Monitor: compare every edge against the queued expectation
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_a_q.size() > 0) check("msb_w4", {4'b0, sout_a, q_a}, {4'b0, exp_a_q.pop_front()});
            if (exp_b_q.size() > 0) check("lsb_w4", {4'b0, sout_b, q_b}, {4'b0, exp_b_q.pop_front()});
            if (exp_c_q.size() > 0) check("msb_w8", {sout_c, q_c}, exp_c_q.pop_front());
        end
    end

    // Stimulus
    initial begin
        logic [7:0] one8;
        logic [8:0] ec;
        one8 = 8'd1;

        // Reset for one edge
        step_hand(1'b0, 1'b0, 5'b0_0000, 5'b0_0000, 9'b0_00000000);

        // Shift 1,0,1,1
        step_hand(1'b1, 1'b1, 5'b0_0001, 5'b0_1000, 9'b0_00000001);
        step_hand(1'b0, 1'b1, 5'b0_0010, 5'b0_0100, 9'b0_00000010);
        step_hand(1'b1, 1'b1, 5'b0_0101, 5'b0_1010, 9'b0_00000101);
        step_hand(1'b1, 1'b1, 5'b1_1011, 5'b1_1101, 9'b0_00001011);

        // Pseudo-random bits against the reference FIFO
        repeat (16) step_model(1'($urandom_range(0, 1)), 1'b1);

        // Fill with ones, then reset mid-stream
        repeat (4) step_model(1'b1, 1'b1);
        step_hand(1'b0, 1'b0, 5'b0_0000, 5'b0_0000, 9'b0_00000000);
        step_hand(1'b1, 1'b1, 5'b0_0001, 5'b0_1000, 9'b0_00000001);
        repeat (2) step_model(1'b0, 1'b1);

        // Single 1 then zeros: direction check and 8-stage pulse
        step_hand(1'b0, 1'b0, 5'b0_0000, 5'b0_0000, 9'b0_00000000);
        step_hand(1'b1, 1'b1, 5'b0_0001, 5'b0_1000, 9'b0_00000001);
        step_hand(1'b0, 1'b1, 5'b0_0010, 5'b0_0100, 9'b0_00000010);
        step_hand(1'b0, 1'b1, 5'b0_0100, 5'b0_0010, 9'b0_00000100);
        step_hand(1'b0, 1'b1, 5'b1_1000, 5'b1_0001, 9'b0_00001000);
        for (int n = 5; n <= 10; n++) begin
            ec = {(n == 8), (n <= 8) ? (one8 << (n - 1)) : 8'd0};
            step_hand(1'b0, 1'b1, 5'b0_0000, 5'b0_0000, ec);
        end

        repeat (2) @(negedge clock);
        checks++;
        if (exp_a_q.size() + exp_b_q.size() + exp_c_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0",
                     exp_a_q.size() + exp_b_q.size() + exp_c_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_siso_4_bit
